// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit patterns and
// the nibble codes reported for blank and undecodable patterns.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] M_A = 7'(1) << SEG_A;
    localparam logic [6:0] M_B = 7'(1) << SEG_B;
    localparam logic [6:0] M_C = 7'(1) << SEG_C;
    localparam logic [6:0] M_D = 7'(1) << SEG_D;
    localparam logic [6:0] M_E = 7'(1) << SEG_E;
    localparam logic [6:0] M_F = 7'(1) << SEG_F;
    localparam logic [6:0] M_G = 7'(1) << SEG_G;

    localparam logic [6:0] SEG7_0     = M_A | M_B | M_C | M_D | M_E | M_F;
    localparam logic [6:0] SEG7_1     = M_B | M_C;
    localparam logic [6:0] SEG7_2     = M_A | M_B | M_D | M_E | M_G;
    localparam logic [6:0] SEG7_3     = M_A | M_B | M_C | M_D | M_G;
    localparam logic [6:0] SEG7_4     = M_B | M_C | M_F | M_G;
    localparam logic [6:0] SEG7_5     = M_A | M_C | M_D | M_F | M_G;
    localparam logic [6:0] SEG7_6     = M_A | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_7     = M_A | M_B | M_C | M_F;
    localparam logic [6:0] SEG7_8     = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_9     = M_A | M_B | M_C | M_D | M_F | M_G;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    localparam logic [3:0] NIB_ERR   = 4'hF;
    localparam logic [3:0] NIB_BLANK = 4'h0;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational inverse of the hex-to-segment encoder: 7-bit pattern to
// nibble plus blank/error flags. The decimal point is handled by the caller.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg7_dec_t  dec
);

    always_comb begin
        dec.nibble = NIB_ERR;
        dec.blank  = 1'b0;
        dec.err    = 1'b0;
        case (pattern)
            SEG7_BLANK: begin
                dec.nibble = NIB_BLANK;
                dec.blank  = 1'b1;
            end
            SEG7_0:  dec.nibble = 4'd0;
            SEG7_1:  dec.nibble = 4'd1;
            SEG7_2:  dec.nibble = 4'd2;
            SEG7_3:  dec.nibble = 4'd3;
            SEG7_4:  dec.nibble = 4'd4;
            SEG7_5:  dec.nibble = 4'd5;
            SEG7_6:  dec.nibble = 4'd6;
            SEG7_7:  dec.nibble = 4'd7;
            SEG7_8:  dec.nibble = 4'd8;
            SEG7_9:  dec.nibble = 4'd9;
            default: dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus, accepts each digit after a stability
// dwell and pulses frame_valid once every digit has been refreshed.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    output logic                    sel_err
);

    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [NUM_DIGITS-1:0] updated;
    logic [CW-1:0]         cnt;
    logic                  done;
    seg7_dec_t             dec;
    logic                  in_changed;
    logic                  accept;
    logic [NUM_DIGITS-1:0] acc_mask;

    function automatic logic multi_hot(input logic [NUM_DIGITS-1:0] v);
        return (v & (v - NUM_DIGITS'(1))) != '0;
    endfunction

    seg7_pattern_dec u_dec (
        .pattern (r_seg[6:0]),
        .dec     (dec)
    );

    assign in_changed = (seg_in != r_seg) || (dig_sel != r_sel);
    assign accept     = (cnt == CNT_MAX) && (r_sel != '0) && !multi_hot(r_sel) && !done;
    assign acc_mask   = accept ? r_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg       <= '0;
            r_sel       <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            updated     <= '0;
            digits_out  <= '0;
            blank_out   <= '0;
            dp_out      <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            r_seg   <= seg_in;
            r_sel   <= dig_sel;
            sel_err <= (dig_sel != r_sel) && multi_hot(dig_sel);

            // done latches one accept per dwell; any input change starts a new dwell
            if (in_changed) begin
                cnt  <= '0;
                done <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                if (accept) done <= 1'b1;
            end

            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (acc_mask[i]) begin
                    digits_out[4*i +: 4] <= dec.nibble;
                    blank_out[i]         <= dec.blank;
                    dp_out[i]            <= r_seg[SEG_DP];
                    err_out[i]           <= dec.err;
                end
            end

            // An accept on the pulse edge seeds the next frame's mask
            if (&updated) begin
                frame_valid <= 1'b1;
                updated     <= acc_mask;
            end else begin
                frame_valid <= 1'b0;
                updated     <= updated | acc_mask;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (4 digits, dwell of 4): vector table
// plus hand-stepped latency, reset-mid-dwell and frame-timing sequences.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] digits_out;
    logic [3:0]  blank_out, dp_out, err_out;
    logic        frame_valid, sel_err;

    int n_vec = 0;
    int n_err = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    typedef struct {
        logic [7:0]  seg;
        logic [3:0]  sel;
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  err;
        int          fv;
        int          se;
    } vec_t;

    vec_t tbl[13];

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digits_out  (digits_out),
        .blank_out   (blank_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .frame_valid (frame_valid),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (frame_valid === 1'b1) fv_cnt++;
        if (sel_err === 1'b1) se_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " digits"}, 32'(digits_out), 32'h0);
        check({tag, " blank"}, 32'(blank_out), 32'h0);
        check({tag, " dp"}, 32'(dp_out), 32'h0);
        check({tag, " err"}, 32'(err_out), 32'h0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, " sel_err"}, 32'(sel_err), 32'h0);
    endtask

    initial begin
        int fv_base;

        tbl[0]  = '{8'h6D, 4'b0001, 8,  16'h0005, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[1]  = '{8'h4F, 4'b0010, 8,  16'h0035, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[2]  = '{8'h5B, 4'b0100, 8,  16'h0235, 4'b0000, 4'b0000, 4'b0000, 0, 0};
        tbl[3]  = '{8'h06, 4'b1000, 8,  16'h1235, 4'b0000, 4'b0000, 4'b0000, 1, 0};
        tbl[4]  = '{8'h00, 4'b0100, 8,  16'h1035, 4'b0100, 4'b0000, 4'b0000, 1, 0};
        tbl[5]  = '{8'h55, 4'b1000, 8,  16'hF035, 4'b0100, 4'b0000, 4'b1000, 1, 0};
        tbl[6]  = '{8'hBF, 4'b0001, 8,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 0};
        tbl[7]  = '{8'h66, 4'b0010, 3,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 0};
        tbl[8]  = '{8'h67, 4'b0010, 1,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 0};
        tbl[9]  = '{8'h66, 4'b0010, 3,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 0};
        tbl[10] = '{8'h66, 4'b0000, 8,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 0};
        tbl[11] = '{8'h06, 4'b0011, 10, 16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 1};
        tbl[12] = '{8'h06, 4'b0000, 4,  16'hF030, 4'b0100, 4'b0001, 4'b1000, 1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table-driven scan, decode corners, glitch and select faults
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].seg, tbl[i].sel, tbl[i].cyc);
            check($sformatf("v%0d digits", i), 32'(digits_out), 32'(tbl[i].digits));
            check($sformatf("v%0d blank", i), 32'(blank_out), 32'(tbl[i].blank));
            check($sformatf("v%0d dp", i), 32'(dp_out), 32'(tbl[i].dp));
            check($sformatf("v%0d err", i), 32'(err_out), 32'(tbl[i].err));
            check($sformatf("v%0d frames", i), 32'(fv_cnt), 32'(tbl[i].fv));
            check($sformatf("v%0d sel_err pulses", i), 32'(se_cnt), 32'(tbl[i].se));
        end

        // Latency: held 7F on digit0 from edge 1 accepts at edge 5
        rst_n   = 1'b0;
        seg_in  = 8'h7F;
        dig_sel = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        fv_base = fv_cnt;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("latency edge%0d", k), 32'(digits_out), (k < 5) ? 32'h0 : 32'h8);
        end
        repeat (15) @(negedge clk);
        check("long dwell digits", 32'(digits_out), 32'h0008);
        check("long dwell frames", 32'(fv_cnt), 32'(fv_base));

        // Reset mid-dwell at cnt=2
        apply(8'h6F, 4'b0010, 3);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid-dwell reset");
        @(negedge clk);
        rst_n = 1'b1;
        fv_base = fv_cnt;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("post-reset edge%0d", k), 32'(digits_out), (k < 5) ? 32'h0 : 32'h0090);
        end

        // Frame completes only after all four digits are re-accepted
        apply(8'h3F, 4'b0001, 8);
        apply(8'h66, 4'b0100, 8);
        check("partial frame", 32'(fv_cnt), 32'(fv_base));
        apply(8'h6D, 4'b1000, 5);
        check("last accept digits", 32'(digits_out), 32'h5490);
        check("fv at accept edge", 32'(frame_valid), 32'h0);
        @(negedge clk);
        check("fv one edge later", 32'(frame_valid), 32'h1);
        @(negedge clk);
        check("fv width", 32'(frame_valid), 32'h0);
        check("frame count", 32'(fv_cnt), 32'(fv_base + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
